// File: rtl/generador_codigo_gray.sv
// Gray-code source: prescaled up/down binary counter with a
// registered reflected-Gray copy and a one-cycle step pulse.
module generador_codigo_gray #(
    parameter int WIDTH = 4,
    parameter int DIV   = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             paso
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    logic [PW-1:0]    pre_cnt;
    logic             terminal;
    logic             step;
    logic [WIDTH-1:0] bin_next;

    function automatic logic [WIDTH-1:0] to_gray(
        input logic [WIDTH-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    assign terminal = (pre_cnt == TERM);
    assign step     = en && terminal && !load;

    // Next binary value for a counted step, wrapping modulo 2^WIDTH
    always_comb begin
        bin_next = bin;
        if (up) bin_next = bin + WIDTH'(1);
        else    bin_next = bin - WIDTH'(1);
    end

    // Prescaler: counts enabled cycles, pauses while en is low
    always_ff @(posedge clk) begin
        if (rst || load) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (terminal) pre_cnt <= '0;
            else          pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Binary and Gray registers; Gray taken from the next binary value
    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
        end else if (load) begin
            bin  <= load_val;
            gray <= to_gray(load_val);
        end else if (step) begin
            bin  <= bin_next;
            gray <= to_gray(bin_next);
        end
    end

    // Step pulse, high for the cycle following a counted step
    always_ff @(posedge clk) begin
        if (rst) paso <= 1'b0;
        else     paso <= step;
    end

endmodule

// File: tb/tb_generador_codigo_gray.sv
// Bench for generador_codigo_gray: DIV=4 and DIV=1 instances on shared
// stimulus, checked every cycle against a behavioural counter model.
module tb_generador_codigo_gray;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] load_val;
    logic [3:0] bin4, gray4, bin1, gray1;
    logic       paso4, paso1;

    int vectors = 0;
    int miscompares = 0;

    int m_bin [2];
    int m_cnt [2];
    int m_paso[2];
    int m_prev[2];
    int m_step[2];
    int divs  [2] = '{4, 1};
    bit armed = 1'b0;

    always #5 clk = ~clk;

    generador_codigo_gray #(.WIDTH(4), .DIV(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .bin(bin4), .gray(gray4), .paso(paso4)
    );

    generador_codigo_gray #(.WIDTH(4), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .bin(bin1), .gray(gray1), .paso(paso1)
    );

    function automatic int g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: enabled cycles since last step/load/reset
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_step[k] = 0;
            if (rst) begin
                m_bin[k] = 0; m_cnt[k] = 0; m_paso[k] = 0;
            end else if (load) begin
                m_bin[k] = load_val; m_cnt[k] = 0; m_paso[k] = 0;
            end else if (en) begin
                if (m_cnt[k] + 1 == divs[k]) begin
                    m_prev[k] = g(m_bin[k]);
                    m_bin[k]  = up ? (m_bin[k] + 1) % 16
                                   : (m_bin[k] + 15) % 16;
                    m_cnt[k]  = 0;
                    m_paso[k] = 1;
                    m_step[k] = 1;
                end else begin
                    m_cnt[k]++;
                    m_paso[k] = 0;
                end
            end else begin
                m_paso[k] = 0;
            end
        end
        if (rst) armed = 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("bin4",  bin4,  m_bin[0]);
            chk("gray4", gray4, g(m_bin[0]));
            chk("paso4", paso4, m_paso[0]);
            chk("bin1",  bin1,  m_bin[1]);
            chk("gray1", gray1, g(m_bin[1]));
            chk("paso1", paso1, m_paso[1]);
            if (m_step[0])
                chk("onebit4", $countones(gray4 ^ m_prev[0][3:0]), 1);
            if (m_step[1])
                chk("onebit1", $countones(gray1 ^ m_prev[1][3:0]), 1);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int seq[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    int npulse;

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        edges(2);
        chk("rst_bin", bin4, 0);
        chk("rst_gray", gray4, 0);
        chk("rst_paso", paso4, 0);

        // Up count through the full Gray cycle
        rst = 1'b0; en = 1'b1; up = 1'b1;
        npulse = 0;
        for (int i = 0; i < 64; i++) begin
            edges(1);
            if (paso4) begin
                if (npulse < 16) chk("seq", gray4, seq[npulse]);
                npulse++;
            end
        end
        chk("npulse", npulse, 16);

        // Down wrap from a loaded zero
        load = 1'b1; load_val = 4'b0000; up = 1'b0;
        edges(1);
        load = 1'b0;
        edges(4);
        chk("dn_bin", bin4, 15);
        chk("dn_gray", gray4, 8);
        edges(4);
        chk("dn_bin2", bin4, 14);
        chk("dn_gray2", gray4, 9);

        // Pause keeps prescaler position
        load = 1'b1; load_val = 4'b0000; up = 1'b1;
        edges(1);
        load = 1'b0;
        edges(2);
        en = 1'b0;
        edges(10);
        chk("pause_bin", bin4, 0);
        en = 1'b1;
        edges(1);
        chk("pause_paso", paso4, 0);
        edges(1);
        chk("resume_bin", bin4, 1);
        chk("resume_paso", paso4, 1);

        // Load on the terminal-count edge wins
        load = 1'b1; load_val = 4'b0000;
        edges(1);
        load = 1'b0;
        edges(3);
        load = 1'b1; load_val = 4'b1010;
        edges(1);
        load = 1'b0;
        chk("ld_bin", bin4, 10);
        chk("ld_gray", gray4, 15);
        chk("ld_paso", paso4, 0);
        edges(3);
        chk("ld_hold", bin4, 10);
        edges(1);
        chk("ld_bin2", bin4, 11);
        chk("ld_gray2", gray4, 14);

        // Reset during a pulse
        load = 1'b1; load_val = 4'b0110;
        edges(1);
        load = 1'b0;
        edges(4);
        chk("pre_rst_bin", bin4, 7);
        chk("pre_rst_paso", paso4, 1);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        chk("mid_rst_bin", bin4, 0);
        chk("mid_rst_gray", gray4, 0);
        chk("mid_rst_paso", paso4, 0);
        edges(4);
        chk("post_rst_bin", bin4, 1);

        // DIV=1 random direction
        en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            up = 1'($urandom);
            edges(1);
        end

        // Fully random traffic
        for (int i = 0; i < 1500; i++) begin
            en       = ($urandom % 4) != 0;
            up       = 1'($urandom);
            load     = ($urandom % 32) == 0;
            rst      = ($urandom % 128) == 0;
            load_val = 4'($urandom);
            edges(1);
        end
        rst = 1'b0; load = 1'b0;
        edges(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
